// File: rtl/dpram_be.sv
// One-read/one-write block RAM with per-lane write enables, 1- or 2-cycle read latency,
// optional same-cycle write-to-read bypass and a post-reset zeroing sequencer.
//
// state | meaning
// IDLE  | normal traffic, busy=0
// CLEAR | writing zero to mem[cnt] each cycle, traffic ignored, busy=1
module dpram_be #(
  parameter int ADDR_WIDTH     = 9,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_LANES      = 4,
  parameter int RD_LATENCY     = 1,
  parameter int BYPASS         = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ract,
  input  logic [ADDR_WIDTH-1:0] ra,
  output logic [DATA_WIDTH-1:0] rdr,
  output logic                  rvalid,
  input  logic                  wact,
  input  logic [ADDR_WIDTH-1:0] wa,
  input  logic [DATA_WIDTH-1:0] wdw,
  input  logic [NUM_LANES-1:0]  wbe,
  output logic                  busy
);

  localparam int LW    = DATA_WIDTH / NUM_LANES;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] CNT_ONE = ADDR_WIDTH'(1);

  if (DATA_WIDTH % NUM_LANES != 0) begin : g_bad_lanes
    $fatal(1, "dpram_be: DATA_WIDTH must be a multiple of NUM_LANES");
  end
  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
    $fatal(1, "dpram_be: RD_LATENCY must be 1 or 2");
  end

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic                    clr_we, rd_fire, wr_fire;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DATA_WIDTH-1:0]   rd_word;
  logic [DATA_WIDTH-1:0]   s1_data;
  logic                    s1_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) cnt <= cnt + CNT_ONE;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (cnt == '1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // busy is tied low outright when clearing is disabled, even before the first reset
  always_comb begin
    busy    = (CLEAR_ON_RESET != 0) && (state == CLEAR);
    clr_we  = busy && !rst;
    rd_fire = ract && !busy && !rst;
    wr_fire = wact && !busy && !rst;
  end

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[cnt] <= '0;
    end else if (wr_fire) begin
      for (int i = 0; i < NUM_LANES; i++)
        if (wbe[i]) mem[wa][i*LW +: LW] <= wdw[i*LW +: LW];
    end
  end

  always_comb begin
    rd_word = mem[ra];
    if (BYPASS != 0 && wr_fire && ra == wa)
      for (int i = 0; i < NUM_LANES; i++)
        if (wbe[i]) rd_word[i*LW +: LW] = wdw[i*LW +: LW];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= rd_fire;
      if (rd_fire) s1_data <= rd_word;
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] s2_data;
    logic                  s2_valid;

    always_ff @(posedge clk) begin
      if (rst) begin
        s2_data  <= '0;
        s2_valid <= 1'b0;
      end else begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_data <= s1_data;
      end
    end

    assign rdr    = s2_data;
    assign rvalid = s2_valid;
  end else begin : g_lat1
    assign rdr    = s1_data;
    assign rvalid = s1_valid;
  end

endmodule

// File: tb/tb_dpram_be.sv
// Drives two dpram_be instances (latency 2 + bypass, latency 1 + no bypass) from shared
// stimulus and compares both against an array/queue reference model.
module tb_dpram_be;

  logic        clk;
  logic        rst;
  logic        ract, wact;
  logic [3:0]  ra, wa;
  logic [31:0] wdw;
  logic [3:0]  wbe;
  logic [31:0] rdr_a, rdr_b;
  logic        rvalid_a, rvalid_b, busy_a, busy_b;

  dpram_be #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .NUM_LANES(4), .RD_LATENCY(2),
             .BYPASS(1), .CLEAR_ON_RESET(1)) dut_a (
    .clk(clk), .rst(rst), .ract(ract), .ra(ra), .rdr(rdr_a), .rvalid(rvalid_a),
    .wact(wact), .wa(wa), .wdw(wdw), .wbe(wbe), .busy(busy_a));

  dpram_be #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .NUM_LANES(4), .RD_LATENCY(1),
             .BYPASS(0), .CLEAR_ON_RESET(1)) dut_b (
    .clk(clk), .rst(rst), .ract(ract), .ra(ra), .rdr(rdr_b), .rvalid(rvalid_b),
    .wact(wact), .wa(wa), .wdw(wdw), .wbe(wbe), .busy(busy_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] data;
  } rd_t;

  logic [31:0] mdl [16];
  rd_t         qa[$], qb[$];
  logic [31:0] last_a, last_b;
  int          after_rst;
  int          k;
  int          n_vec, n_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, k);
    end
  endtask

  function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] d,
                                             input logic [3:0] be);
    logic [31:0] mask;
    mask = 32'h0;
    for (int i = 0; i < 4; i++)
      if (be[i]) mask = mask | (32'hFF << (8 * i));
    return (old & ~mask) | (d & mask);
  endfunction

  // Memory reads as all-zero once the clear finishes; traffic is ignored for 16 cycles.
  task automatic model_edge();
    rd_t         e;
    logic [31:0] old;
    if (rst) begin
      qa.delete();
      qb.delete();
      last_a    = 32'h0;
      last_b    = 32'h0;
      after_rst = 0;
      for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
    end else begin
      if (after_rst >= 16) begin
        if (ract) begin
          old    = mdl[ra];
          e.due  = k + 1;
          e.data = (wact && wa == ra) ? lane_merge(old, wdw, wbe) : old;
          qa.push_back(e);
          e.due  = k;
          e.data = old;
          qb.push_back(e);
        end
        if (wact) mdl[wa] = lane_merge(mdl[wa], wdw, wbe);
      end
      if (after_rst < 16) after_rst++;
    end
  endtask

  task automatic compare();
    chk("busy_a", {31'b0, busy_a}, {31'b0, after_rst < 16});
    chk("busy_b", {31'b0, busy_b}, {31'b0, after_rst < 16});
    if (qa.size() > 0 && qa[0].due == k) begin
      chk("rvalid_a", {31'b0, rvalid_a}, 32'h1);
      chk("rdr_a", rdr_a, qa[0].data);
      last_a = qa[0].data;
      void'(qa.pop_front());
    end else begin
      chk("rvalid_a_idle", {31'b0, rvalid_a}, 32'h0);
      chk("rdr_a_hold", rdr_a, last_a);
    end
    if (qb.size() > 0 && qb[0].due == k) begin
      chk("rvalid_b", {31'b0, rvalid_b}, 32'h1);
      chk("rdr_b", rdr_b, qb[0].data);
      last_b = qb[0].data;
      void'(qb.pop_front());
    end else begin
      chk("rvalid_b_idle", {31'b0, rvalid_b}, 32'h0);
      chk("rdr_b_hold", rdr_b, last_b);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    compare();
    k++;
  endtask

  task automatic drive(input bit r, input bit rd, input int rad, input bit wr, input int wad,
                       input logic [31:0] d, input logic [3:0] be);
    rst  = r;
    ract = rd;
    ra   = rad[3:0];
    wact = wr;
    wa   = wad[3:0];
    wdw  = d;
    wbe  = be;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 32'h0, 4'h0);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    n_vec = 0; n_err = 0; k = 0; after_rst = 0;
    last_a = 32'h0; last_b = 32'h0;
    drive(1, 0, 0, 0, 0, 32'h0, 4'h0);
    repeat (3) cyc();

    // Traffic during clear must be dropped
    drive(0, 1, 7, 1, 7, 32'h12345678, 4'hF);
    repeat (4) cyc();
    drive(0, 1, 2, 1, 2, 32'hDEADBEEF, 4'hF);
    repeat (4) cyc();
    idle(10);

    for (int i = 0; i < 16; i++) begin
      drive(0, 1, i, 0, 0, 32'h0, 4'h0);
      cyc();
    end
    idle(3);

    drive(0, 0, 0, 1, 3, 32'hAABBCCDD, 4'b1111); cyc();
    drive(0, 0, 0, 1, 3, 32'h11223344, 4'b0101); cyc();
    drive(0, 1, 3, 0, 0, 32'h0, 4'h0);           cyc();
    idle(3);

    drive(0, 0, 0, 1, 1, 32'h01010101, 4'hF); cyc();
    drive(0, 0, 0, 1, 2, 32'h02020202, 4'hF); cyc();
    for (int i = 1; i <= 3; i++) begin
      drive(0, 1, i, 0, 0, 32'h0, 4'h0);
      cyc();
    end
    idle(4);

    drive(0, 1, 5, 1, 5, 32'hFFFFFFFF, 4'b0011); cyc();
    drive(0, 1, 5, 0, 0, 32'h0, 4'h0);           cyc();
    idle(3);

    // Reset with a read in flight, then again partway through the clear
    drive(0, 1, 3, 0, 0, 32'h0, 4'h0); cyc();
    drive(1, 1, 3, 0, 0, 32'h0, 4'h0); cyc();
    drive(0, 1, 4, 1, 4, 32'h5A5A5A5A, 4'hF);
    repeat (8) cyc();
    drive(1, 0, 0, 0, 0, 32'h0, 4'h0); cyc();
    drive(0, 1, 6, 1, 6, 32'hA5A5A5A5, 4'hF);
    repeat (16) cyc();
    idle(2);
    drive(0, 1, 6, 0, 0, 32'h0, 4'h0); cyc();
    idle(3);

    for (int i = 0; i < 500; i++) begin
      int rad, wad;
      rad = $urandom_range(0, 15);
      wad = ($urandom_range(0, 3) == 0) ? rad : $urandom_range(0, 15);
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 1), rad, $urandom_range(0, 1),
            wad, $urandom, 4'($urandom_range(0, 15)));
      cyc();
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dpram_be.md
Name: dpram_be

Overview:
Parametrised successor to the team's 1-read/1-write block SRAM, used for FFT working buffers and twiddle/sample storage. It adds:
- per-lane byte-style write enables
- selectable read latency (1 or 2) with a read-valid strobe
- optional same-cycle write-to-read bypass
- a post-reset clear sequencer that zeroes the whole array before accepting traffic

Parameters:
ADDR_WIDTH, 9, address bits; depth = 2**ADDR_WIDTH words
DATA_WIDTH, 32, word width in bits
NUM_LANES, 4, write-enable lanes; lane width LW = DATA_WIDTH/NUM_LANES
RD_LATENCY, 1, cycles from ract sample to rdr/rvalid; legal values 1 or 2
BYPASS, 1, 1 = same-address same-cycle read returns newly written lanes; 0 = returns old contents
CLEAR_ON_RESET, 1, 1 = zero all words after reset; 0 = no clear, memory contents undefined after power-up

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous, active-high reset
ract  in  1  read request
ra  in  ADDR_WIDTH  read address
rdr  out  DATA_WIDTH  read data
rvalid  out  1  rdr carries data for a read issued RD_LATENCY cycles earlier
wact  in  1  write request
wa  in  ADDR_WIDTH  write address
wdw  in  DATA_WIDTH  write data
wbe  in  NUM_LANES  lane enables; bit i covers wdw[i*LW +: LW]
busy  out  1  clear sequence in progress; ract/wact ignored

Behaviour:
- Elaboration: fatal error if DATA_WIDTH % NUM_LANES != 0 or RD_LATENCY not in {1,2}.
- Reset (rst high at edge):
  - rdr=0, rvalid=0, all pipeline stages and valids cleared.
  - busy=1 if CLEAR_ON_RESET else 0.
  - Clear counter=0.
  - Memory contents untouched by rst itself.
- Clear FSM, states IDLE and CLEAR:
  - rst with CLEAR_ON_RESET=1 -> CLEAR.
  - In CLEAR: each cycle writes 0 to mem[cnt], cnt++.
  - The cycle writing address 2**ADDR_WIDTH-1 transitions to IDLE.
  - busy is high for exactly 2**ADDR_WIDTH cycles after rst deasserts.
  - rst asserted during CLEAR restarts at cnt=0.
  - CLEAR_ON_RESET=0: FSM stays IDLE and busy is constant 0.
- Busy gating: ract/wact with busy=1 have no effect (no write, no rvalid).
- Write: on edge with wact=1 and busy=0, for each i with wbe[i]=1, mem[wa] lane i <= wdw lane i. Other lanes keep their value. wbe=0 is a no-op.
- Read, stage 1: on edge with ract=1 and busy=0, the word at ra is captured.
- Read, RD_LATENCY=1: rdr = captured word and rvalid=1 in the following cycle.
- Read, RD_LATENCY=2: one extra output register; data and rvalid appear two cycles after the ract edge.
- Read pipelining: back-to-back reads every cycle are supported, with throughput 1/cycle.
- Idle output: rvalid=0 in cycles with no returning read; rdr holds the last returned value and does not return to 0.
- Collision (ract, wact, ra==wa, same edge):
  - BYPASS=1: returned word = wdw on lanes with wbe set, old contents on the others.
  - BYPASS=0: returned word = contents before the write.
  - Memory is updated in both modes.
- Different addresses in the same cycle: fully independent.
- Reset mid-read: in-flight reads are discarded; no rvalid after reset.

Test Plan:
- Clear: CLEAR_ON_RESET=1, ADDR_WIDTH=4; release rst -> busy high exactly 16 cycles. Then read addrs 0..15 -> all 0x00000000 with rvalid.
- Byte enables: write 0xAABBCCDD wbe=4'b1111 to addr 3, then 0x11223344 wbe=4'b0101 to addr 3; read 3 -> 0xAA22CC44.
- Latency: RD_LATENCY=2; reads of addrs 1,2,3 on consecutive cycles -> rvalid high on cycles +2,+3,+4 with the matching data. rvalid low otherwise; rdr holds the last value.
- Collision: mem[5]=0x00000000; same edge write 0xFFFFFFFF wbe=4'b0011 to 5 and read 5. BYPASS=1 -> 0x0000FFFF; BYPASS=0 -> 0x00000000. A subsequent read in both modes -> 0x0000FFFF.
- Busy gating: write 0x12345678 to addr 7 during CLEAR -> after busy falls, read 7 returns 0. No rvalid for reads issued while busy.
- Reset mid-operation: assert rst midway through CLEAR and with a read in flight -> no rvalid afterwards, busy restarts for the full 2**ADDR_WIDTH cycles, rdr=0.
